// File: rtl/seg_595_static.sv
// seg_595_static
// Static 6-digit hex display driver for a 74HC595 shift-register pair.
// A 4-bit digit counts 0x0..0xF, advancing once every CNT_MAX+1 clocks.
// Its seven-segment code is shown on all six digits at once. Each 14-bit
// frame {seg[0..7], sel[5:0]} is shifted out LSB first, one bit every
// 4 clocks, and latched with a one-clock stcp pulse. Frames run back to back.
//
// Ports:
//   sys_clk    in   system clock (50 MHz nominal)
//   sys_rst_n  in   synchronous reset, ACTIVE HIGH despite the _n suffix
//   ds         out  serial data to 595 DS
//   stcp       out  storage latch clock to 595 STCP, one-clock pulse per frame
//   shcp       out  shift clock to 595 SHCP, period 4 clocks, 50% duty
//   oe         out  595 output enable, active low
module seg_595_static #(
  parameter int CNT_MAX = 24_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic ds,
  output logic stcp,
  output logic shcp,
  output logic oe
);

  localparam int STEP_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(CNT_MAX);

  logic [STEP_W-1:0] cnt_step;
  logic [3:0]        digit;
  logic [1:0]        cnt_4;
  logic [3:0]        cnt_bit;
  logic [13:0]       word;

  // Active-low segment code, bit order {dp,g,f,e,d,c,b,a}, dp always off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Segment bits are reversed so seg[7] is shifted right after the selects
  // and seg[0] goes last; all six digit selects are on.
  function automatic logic [13:0] frame_word(input logic [3:0] d);
    logic [7:0] s;
    s = seg_code(d);
    return {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7], 6'b111111};
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cnt_step <= '0;
      digit    <= 4'd0;
      cnt_4    <= 2'd0;
      cnt_bit  <= 4'd0;
      word     <= frame_word(4'd0);
      ds       <= 1'b0;
      shcp     <= 1'b0;
      stcp     <= 1'b0;
      oe       <= 1'b1;
    end else begin
      oe <= 1'b0;

      if (cnt_step == STEP_MAX) begin
        cnt_step <= '0;
        digit    <= digit + 4'd1;
      end else begin
        cnt_step <= cnt_step + 1'b1;
      end

      cnt_4 <= cnt_4 + 2'd1;
      if (cnt_4 == 2'd3)
        cnt_bit <= (cnt_bit == 4'd13) ? 4'd0 : cnt_bit + 4'd1;

      // Capture only at frame start so a digit step never tears a frame.
      // Bit 0 is a select bit (always 1), so driving it from the
      // previous word on this same edge is harmless.
      if (cnt_bit == 4'd0 && cnt_4 == 2'd0)
        word <= frame_word(digit);

      if (cnt_4 == 2'd0) begin
        ds   <= word[cnt_bit];
        shcp <= 1'b0;
      end else if (cnt_4 == 2'd2) begin
        shcp <= 1'b1;
      end

      stcp <= (cnt_bit == 4'd13) && (cnt_4 == 2'd3);
    end
  end

endmodule

// File: tb/tb_seg_595_static.sv
module tb_seg_595_static;

  localparam int CNT_MAX    = 49;
  localparam int MAIN_FRAMES = 150;
  localparam int POST_FRAMES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ds, stcp, shcp, oe;

  seg_595_static #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst),
    .ds       (ds),
    .stcp     (stcp),
    .shcp     (shcp),
    .oe       (oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] exp_q[$];
  logic [7:0]  codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int stcp_seen = 0;

  task automatic check(input bit ok, input string name, input int act, input int expv);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected serial word for a digit: seg bits reversed above six select ones.
  function automatic logic [13:0] exp_word(input int d);
    logic [7:0]  s;
    logic [13:0] w;
    s = codes[d % 16];
    for (int j = 0; j < 8; j++) w[13-j] = s[j];
    w[5:0] = 6'b111111;
    return w;
  endfunction

  // Frame k starts 56k clocks after release; the digit shown is how many
  // step periods have fully elapsed by then.
  task automatic push_frames(input int frames);
    for (int k = 0; k < frames; k++)
      exp_q.push_back(exp_word((56 * k) / (CNT_MAX + 1)));
  endtask

  // Monitor: rebuild each frame from ds at shcp rising edges, pop on stcp.
  int          nbits;
  logic [13:0] got;
  logic        prev_shcp, prev_stcp;
  int          last_rise, last_stcp, hi_run;
  logic [13:0] expw;

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; got = '0; prev_shcp = 1'b0; prev_stcp = 1'b0;
      last_rise = -1; last_stcp = -1; hi_run = 0;
    end else begin
      if (shcp) hi_run++;
      if (shcp && !prev_shcp) begin
        if (nbits < 14) got[nbits] = ds;
        nbits++;
        if (last_rise >= 0) check(cyc - last_rise == 4, "shcp_period", cyc - last_rise, 4);
        last_rise = cyc;
      end
      if (!shcp && prev_shcp) begin
        check(hi_run == 2, "shcp_high", hi_run, 2);
        hi_run = 0;
      end
      if (stcp) begin
        stcp_seen++;
        check(!prev_stcp, "stcp_width", 2, 1);
        check(nbits == 14, "bits_per_frame", nbits, 14);
        if (last_stcp >= 0) check(cyc - last_stcp == 56, "stcp_spacing", cyc - last_stcp, 56);
        last_stcp = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", got, 0);
        end else begin
          expw = exp_q.pop_front();
          check(got == expw, "frame_word", got, expw);
        end
        nbits = 0;
      end
      prev_shcp = shcp;
      prev_stcp = stcp;
    end
  end

  task automatic check_reset_values(input string tag);
    check(oe == 1'b1,   {tag, "_oe"},   oe,   1);
    check(ds == 1'b0,   {tag, "_ds"},   ds,   0);
    check(shcp == 1'b0, {tag, "_shcp"}, shcp, 0);
    check(stcp == 1'b0, {tag, "_stcp"}, stcp, 0);
  endtask

  // Release reset at a negedge and run a whole number of frames plus 4 clocks.
  task automatic release_and_run(input int frames);
    int n;
    stcp_seen = 0;
    exp_q.delete();
    push_frames(frames);
    rst = 1'b0;
    @(negedge clk);
    check(oe == 1'b0, "oe_after_release", oe, 0);
    n = 1;
    while (!shcp && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(n == 3, "first_shcp_rise", n, 3);
    repeat (56 * frames - n + 4) @(negedge clk);
    check(stcp_seen == frames, "frame_count", stcp_seen, frames);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");

    release_and_run(MAIN_FRAMES);

    // Reset partway into the next frame; the partial frame must be dropped.
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    @(negedge clk);
    check_reset_values("midreset_hold");

    release_and_run(POST_FRAMES);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_595_static.md
Name: seg_595_static

Overview:
- Static 6-digit hex display driver: a 4-bit value counts 0x0–0xF, stepping once per CNT_MAX+1 clocks.
- The value's seven-segment code is shown on all six digits at once.
- Segment and select bits are serialized to an external 74HC595 shift-register pair through the ds, shcp and stcp outputs.
- The block sits at the top of the static-display demo, between the board clock/reset and the 595 pins.

Parameters:
- CNT_MAX, default 24_999_999: terminal value of the step counter; the step period is CNT_MAX+1 clocks (0.5 s at 50 MHz). Benches override it with a small value.

Ports:
- sys_clk  in  1  system clock, 50 MHz nominal.
- sys_rst_n  in  1  synchronous, active-high reset (asserted = 1 despite the suffix); sampled on the sys_clk rising edge.
- ds  out  1  serial data to the 595 DS pin.
- stcp  out  1  storage (latch) clock to the 595 STCP pin; one-cycle high pulse per frame.
- shcp  out  1  shift clock to the 595 SHCP pin.
- oe  out  1  output enable to the 595 OE pin, active low.

Behaviour:
- All logic is on the sys_clk rising edge; every output is registered.
- Reset values:
  - ds=0, shcp=0, stcp=0, oe=1.
  - cnt_step=0, digit=0, cnt_4=0, cnt_bit=0.
  - Frame word = the code for digit 0 (see frame word below).
- oe: 1 while reset is asserted; 0 from the first clock after reset is released.
- Step counter:
  - cnt_step counts 0..CNT_MAX; after CNT_MAX it returns to 0.
  - On the clock where cnt_step==CNT_MAX, digit (4 bits) increments; 0xF wraps to 0x0.
- Segment code, active low, bit order {dp,g,f,e,d,c,b,a}; dp is always off (bit7=1):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E
- Digit select sel[5:0] is constant 6'b111111 (all digits on).
- Frame word (14 bits):
  - word[13:0] = {seg[0],seg[1],seg[2],seg[3],seg[4],seg[5],seg[6],seg[7],sel[5:0]}.
  - Bit index 0 (sel[0]) is shifted first; index 13 (seg[0]) is shifted last.
- Frame-word capture: the word is captured from the current digit only when cnt_bit==0 and cnt_4==0. A digit change mid-frame therefore never alters a frame in progress.
- Serializer:
  - cnt_4 free-runs 0,1,2,3,0… after reset.
  - cnt_bit increments when cnt_4==3 and wraps 13→0.
  - When cnt_4==0: ds <= word[cnt_bit] and shcp <= 0.
  - When cnt_4==2: shcp <= 1.
  - Otherwise ds and shcp hold.
  - Effect: each bit lasts 4 clocks; ds changes 2 clocks before the shcp rising edge; shcp is high for 2 of every 4 clocks.
- Latch pulse:
  - stcp <= 1 on the clock where cnt_bit==13 and cnt_4==3; otherwise stcp <= 0.
  - stcp is therefore high for exactly one clock, after the 14th shcp rising edge.
- Frames repeat back to back: 56 clocks per frame, one stcp pulse per frame, continuous refresh.
- Reset mid-frame: all counters and outputs return to their reset values on the next edge; the first frame after release restarts at bit 0 with digit 0.

Test Plan:
- Reset for 2 clocks, then release, with CNT_MAX=49 -> during reset oe=1, ds=shcp=stcp=0. One clock after release oe=0. The first shcp rising edge appears 3 clocks after release.
- Capture ds on each shcp rising edge over one frame -> the 14 bits equal 1,1,1,1,1,1,1,1,0,0,0,0,0,0 (sel[0..5], then seg bits 7..0 of C0 for digit 0). Exactly one stcp pulse of one clock occurs, after the 14th rising edge.
- Measure spacing -> shcp period is 4 clocks with 50% duty; stcp pulses are exactly 56 clocks apart.
- Run 17×50 clocks with CNT_MAX=49 -> the latched 8-bit segment values step C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E, then wrap to C0.
- Let a digit step land mid-frame -> the current frame keeps the old code; the next frame carries the new code.
- Assert reset mid-frame, then release -> outputs return to reset values immediately. The next frame starts at bit 0 with code C0.
